music_seq_player: RTL

Multi-channel, parametrised song sequencer for the Basys3 audio path. It generates its own beat tick and steps a beat index through a song of configurable length, with play, pause, stop and loop control. For each channel it drives a 50 % square-wave tone from a half-period count supplied by an external combinational song table. It replaces the fixed-rate beat generator, free-running beat counter and single PWM tone path with one controllable block feeding the PMOD amplifier.

---
 rtl/music_pkg.sv | 33 +++
 rtl/music_tone_div.sv | 54 +++++
 rtl/music_seq_player.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// ---------------------------------------------------------------------------
// music_pkg
// Shared definitions for the song sequencer:
//   - state_e       : player FSM states (IDLE / PLAY / PAUSE)
//   - HP_*          : note half-period counts in clock cycles for a 100 MHz
//                     clock (half-period = 100e6 / (2 * f_note))
//   - HP_REST       : half-period value meaning "no tone"
//   - halfPeriodOf  : helper to derive a half-period for other clock rates
// ---------------------------------------------------------------------------
package music_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int HP_REST = 0;
  localparam int HP_C4   = 191110;
  localparam int HP_D4   = 170265;
  localparam int HP_E4   = 151686;
  localparam int HP_F4   = 143172;
  localparam int HP_G4   = 127551;
  localparam int HP_A4   = 113636;
  localparam int HP_B4   = 101239;
  localparam int HP_C5   = 95556;

  // Half-period in clock cycles of a square wave at toneHz.
  function automatic int halfPeriodOf(input int clkHz, input int toneHz);
    return clkHz / (2 * toneHz);
  endfunction

endpackage

// File: rtl/music_tone_div.sv
// ---------------------------------------------------------------------------
// music_tone_div
// One tone channel: a half-period divider producing a 50 % square wave.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   run          in   advance the divider this cycle (otherwise freeze count
//                     and force the tone low)
//   clear        in   restart the note at phase 0 (count 0, tone low)
//   half_period  in   HP_W-bit half-period in clock cycles, 0 = rest
//   tone         out  registered square wave
// ---------------------------------------------------------------------------
module music_tone_div #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            tone
);

  logic [HP_W-1:0] cnt_q;
  logic            tone_q;

  // Divider counter and output. Clear beats run so every beat change starts
  // the note at phase 0. When not running the count is held (so a paused note
  // resumes where it left off) but the output is silenced. The terminal test
  // uses >= so a half-period that shrinks mid-note still toggles on the next
  // comparison instead of wrapping the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (!run) begin
      tone_q <= 1'b0;
    end else if (half_period == '0) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else if (cnt_q >= half_period - 1'b1) begin
      cnt_q  <= '0;
      tone_q <= ~tone_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/music_seq_player.sv
// ---------------------------------------------------------------------------
// music_seq_player
// Multi-channel song sequencer: generates its own beat tick, steps a beat
// index through a song with play / pause / stop / loop control, and drives
// one square-wave tone per channel from an external half-period table.
// Optional feature macro: MUSIC_MIX_EN (time-division mix on audio_mix).
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          pulse: play from beat 0 (IDLE) or resume (PAUSE)
//   pause          pulse: freeze playback while playing
//   stop           pulse: return to IDLE from any state
//   loop_en        level: wrap to beat 0 after the last beat
//   half_period    NUM_CH*HP_W per-channel half-periods, 0 = rest
//   ibeat          current beat index (song table address)
//   playing        high while in PLAY
//   done           one-cycle pulse at a non-looping end of song
//   tone_out       per-channel square waves
//   audio_mix      single-pin mix of the channels
// ---------------------------------------------------------------------------
module music_seq_player #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BEAT_HZ  = 8,
  parameter int BEAT_LEN = 128,
  parameter int BEAT_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int HP_W     = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [NUM_CH*HP_W-1:0] half_period,
  output logic [BEAT_W-1:0]      ibeat,
  output logic                   playing,
  output logic                   done,
  output logic [NUM_CH-1:0]      tone_out,
  output logic                   audio_mix
);
  import music_pkg::*;

  localparam int PERIOD = CLK_HZ / BEAT_HZ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_LEN - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    beatCnt_q, beatCnt_d;
  logic [BEAT_W-1:0]   ibeat_q, ibeat_d;
  logic                done_q, done_d;
  logic                playing_q;
  logic                beatTick;
  logic                runDiv;
  logic                clearDiv;
  logic [NUM_CH-1:0]   toneBus;

  // Beat tick is the terminal count of the beat counter while playing.
  assign beatTick = (state_q == PLAY) && (beatCnt_q == CNT_LAST);

  // Next-state logic. Commands are resolved stop > pause > start. The beat
  // counter and dividers only advance in PLAY when no command is leaving it,
  // so a pause freezes them at exactly the values seen in the pause cycle.
  // Any beat index change (step, wrap, stop, end of song) clears the
  // dividers so the next note starts at phase 0.
  always_comb begin
    state_d   = state_q;
    beatCnt_d = beatCnt_q;
    ibeat_d   = ibeat_q;
    done_d    = 1'b0;
    runDiv    = 1'b0;
    clearDiv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        clearDiv  = 1'b1;
        ibeat_d   = '0;
        beatCnt_d = '0;
        if (!stop && !pause && start) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d   = IDLE;
          ibeat_d   = '0;
          beatCnt_d = '0;
          clearDiv  = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (beatTick) begin
          beatCnt_d = '0;
          clearDiv  = 1'b1;
          if (ibeat_q == LAST_BEAT) begin
            ibeat_d = '0;
            if (!loop_en) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            ibeat_d = ibeat_q + 1'b1;
          end
        end else begin
          beatCnt_d = beatCnt_q + 1'b1;
          runDiv    = 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d   = IDLE;
          ibeat_d   = '0;
          beatCnt_d = '0;
          clearDiv  = 1'b1;
        end else if (start) begin
          state_d = PLAY;
        end
      end
      default: begin
        state_d   = IDLE;
        ibeat_d   = '0;
        beatCnt_d = '0;
        clearDiv  = 1'b1;
      end
    endcase
  end

  // State and registered outputs. playing is registered from the next state
  // so it lines up with the state and the ibeat update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      beatCnt_q <= '0;
      ibeat_q   <= '0;
      done_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beatCnt_q <= beatCnt_d;
      ibeat_q   <= ibeat_d;
      done_q    <= done_d;
      playing_q <= (state_d == PLAY);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    music_tone_div #(
      .HP_W(HP_W)
    ) u_div (
      .clk         (clk),
      .reset       (reset),
      .run         (runDiv),
      .clear       (clearDiv),
      .half_period (half_period[c*HP_W +: HP_W]),
      .tone        (toneBus[c])
    );
  end

`ifdef MUSIC_MIX_EN
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0] sel_q;
  logic             mix_q;

  // Time-division mix: visit one channel per clock and register its tone.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      mix_q <= 1'b0;
    end else begin
      sel_q <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      mix_q <= (state_q == PLAY) ? toneBus[sel_q] : 1'b0;
    end
  end

  assign audio_mix = mix_q;
`else
  assign audio_mix = toneBus[0];
`endif

  assign ibeat    = ibeat_q;
  assign playing  = playing_q;
  assign done     = done_q;
  assign tone_out = toneBus;

endmodule
